// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_pkg
//  Purpose  : Shared scan-code constants, key and frame-state encodings, and
//             the game-key lookup used by the PS/2 key decoder.
//  Revision : 1.0  initial release
// ============================================================================
package ps2_pkg;

  // PS/2 set-2 scan codes of interest
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  // Code presented to the game controller
  typedef enum logic [1:0] {
    KEY_UP    = 2'b00,
    KEY_LEFT  = 2'b01,
    KEY_RIGHT = 2'b10,
    KEY_ENTER = 2'b11
  } key_e;

  // Frame receiver states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DATA   = 2'b01,
    ST_PARITY = 2'b10,
    ST_STOP   = 2'b11
  } frame_state_e;

  typedef struct packed {
    logic hit;
    key_e key;
  } key_map_t;

  // Arrow keys only count with the E0 prefix, Enter only without it
  // (keypad Enter is E0 5A and is deliberately not a game key).
  function automatic key_map_t map_key(input logic ext, input logic [7:0] code);
    key_map_t m;
    m.hit = 1'b0;
    m.key = KEY_UP;
    if (ext) begin
      if (code == SC_UP) begin
        m.hit = 1'b1; m.key = KEY_UP;
      end else if (code == SC_LEFT) begin
        m.hit = 1'b1; m.key = KEY_LEFT;
      end else if (code == SC_RIGHT) begin
        m.hit = 1'b1; m.key = KEY_RIGHT;
      end
    end else if (code == SC_ENTER) begin
      m.hit = 1'b1; m.key = KEY_ENTER;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_frame_rx
//  Purpose  : Synchronises the raw PS/2 lines, detects falling clock edges
//             and assembles 11-bit frames (start, 8 data LSB first, odd
//             parity, stop) with an inter-edge timeout.
//  Ports    : clk, rst (async active-low), ps2_clk, ps2_data (raw inputs),
//             rx_byte[7:0], byte_rdy (1-cycle), frame_err (1-cycle)
//  Revision : 1.0  initial release
// ============================================================================
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ      = 100000000,
  parameter int TIMEOUT_US  = 2000,
  parameter int SYNC_STAGES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_rdy,
  output logic       frame_err
);

  localparam int TMO_CYCLES = (CLK_HZ / 1000000) * TIMEOUT_US;
  localparam int TMO_W      = $clog2(TMO_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  frame_state_e           r_state;
  frame_state_e           w_state_nxt;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic                   r_parity;
  logic [TMO_W-1:0]       r_tmo_cnt;
  logic                   r_byte_rdy;
  logic                   r_frame_err;

  logic w_fall, w_data, w_timeout;
  logic w_start, w_shift_en, w_par_en, w_done, w_err;

  // Idle PS/2 lines are high, so the synchronisers reset to 1 to avoid a
  // spurious falling edge straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign w_fall    = r_clk_sync[SYNC_STAGES-1] & ~r_clk_sync[SYNC_STAGES-2];
  assign w_data    = r_data_sync[SYNC_STAGES-1];
  // Counter is held at zero on every edge, so hitting the limit means the
  // keyboard went silent mid-frame.
  assign w_timeout = (r_state != ST_IDLE) && !w_fall &&
                     (r_tmo_cnt == TMO_W'(TMO_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift_en  = 1'b0;
    w_par_en    = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    if (w_timeout) begin
      w_state_nxt = ST_IDLE;
      w_err       = 1'b1;
    end else if (w_fall) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_data) begin
            w_state_nxt = ST_DATA;
            w_start     = 1'b1;
          end
        end
        ST_DATA: begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == 3'd7) w_state_nxt = ST_PARITY;
        end
        ST_PARITY: begin
          w_par_en    = 1'b1;
          w_state_nxt = ST_STOP;
        end
        ST_STOP: begin
          w_state_nxt = ST_IDLE;
          if (w_data && (^{r_shift, r_parity})) w_done = 1'b1;
          else                                  w_err  = 1'b1;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_tmo_cnt   <= '0;
      r_byte_rdy  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_byte_rdy  <= w_done;
      r_frame_err <= w_err;
      if (w_start) begin
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_shift   <= {w_data, r_shift[7:1]};
      end
      if (w_par_en) r_parity <= w_data;
      if ((r_state == ST_IDLE) || w_fall) r_tmo_cnt <= '0;
      else                                r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  // The shift register is not touched again until the next frame's data
  // bits, so it is stable while byte_rdy is high.
  assign rx_byte   = r_shift;
  assign byte_rdy  = r_byte_rdy;
  assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_key_decoder
//  Purpose  : Turns PS/2 keyboard frames into the 2-bit game key code.
//             Handles E0/F0 prefixes so only make events of up, left, right
//             (extended) and enter produce a key_valid strobe.
//  Ports    : clk, rst (async active-low), ps2_clk, ps2_data (raw inputs),
//             keyboard_signal[1:0] (held), key_valid (1-cycle),
//             frame_err (1-cycle)
//  Revision : 1.0  initial release
// ============================================================================
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int CLK_HZ      = 100000000,
  parameter int TIMEOUT_US  = 2000,
  parameter int SYNC_STAGES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [1:0] keyboard_signal,
  output logic       key_valid,
  output logic       frame_err
);

  logic [7:0] w_byte;
  logic       w_byte_rdy;
  logic       w_frame_err;
  key_map_t   w_map;

  logic       r_ext;
  logic       r_brk;
  key_e       r_key;
  logic       r_key_valid;

  ps2_frame_rx #(
    .CLK_HZ      (CLK_HZ),
    .TIMEOUT_US  (TIMEOUT_US),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_frame_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (w_byte),
    .byte_rdy  (w_byte_rdy),
    .frame_err (w_frame_err)
  );

  assign w_map = map_key(r_ext, w_byte);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_key       <= KEY_UP;
      r_key_valid <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_frame_err) begin
        // A corrupted frame may have eaten part of a prefix sequence.
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (w_byte_rdy) begin
        if (w_byte == SC_EXT) begin
          r_ext <= 1'b1;
        end else if (w_byte == SC_BRK) begin
          r_brk <= 1'b1;
        end else if (r_brk) begin
          // Key release: swallow it and start fresh.
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end else begin
          r_ext <= 1'b0;
          if (w_map.hit) begin
            r_key       <= w_map.key;
            r_key_valid <= 1'b1;
          end
        end
      end
    end
  end

  assign keyboard_signal = r_key;
  assign key_valid       = r_key_valid;
  assign frame_err       = w_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_key_decoder
//  Purpose  : Self-checking bench for ps2_key_decoder. Stimulus drives PS/2
//             frames and pushes expected strobes into a scoreboard; a monitor
//             pops and compares whenever key_valid or frame_err fires.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ps2_key_decoder;

  // 1 MHz "system clock" so one cycle is one microsecond
  localparam int CLK_HZ   = 1000000;
  localparam int TMO_US   = 200;
  localparam int SYNC     = 3;
  localparam int HP       = 40;   // half PS/2 bit period in clk cycles (12.5 kHz)
  localparam int GAP      = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [1:0] keyboard_signal;
  logic       key_valid;
  logic       frame_err;

  ps2_key_decoder #(
    .CLK_HZ      (CLK_HZ),
    .TIMEOUT_US  (TMO_US),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ps2_clk         (ps2_clk),
    .ps2_data        (ps2_data),
    .keyboard_signal (keyboard_signal),
    .key_valid       (key_valid),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         err;
    logic [1:0] key;
    int         cyc;   // negative: timing not checked
  } exp_t;

  exp_t       sb[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  bit         m_ext  = 0;
  bit         m_brk  = 0;
  logic [1:0] m_last = 2'b00;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (key_valid || frame_err) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse @%0d: key_valid=%0b frame_err=%0b key=%0d, required no pulse",
                 cyc, key_valid, frame_err, keyboard_signal);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ((frame_err !== e.err) || (key_valid !== !e.err) ||
            (!e.err && keyboard_signal !== e.key) ||
            (e.cyc >= 0 && cyc != e.cyc)) begin
          n_fail++;
          $display("FAIL pulse @%0d: got err=%0b valid=%0b key=%0d, required err=%0b valid=%0b key=%0d at cycle %0d",
                   cyc, frame_err, key_valid, keyboard_signal, e.err, !e.err, e.key, e.cyc);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic push_key(input logic [1:0] k, input int at);
    sb.push_back('{err: 1'b0, key: k, cyc: at});
    m_last = k;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit bad, input int stop_cyc);
    if (bad) begin
      sb.push_back('{err: 1'b1, key: 2'b00, cyc: stop_cyc + SYNC});
      m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (m_brk) begin
      m_ext = 0; m_brk = 0;
    end else begin
      if (m_ext && b == 8'h75)       push_key(2'b00, stop_cyc + SYNC + 1);
      else if (m_ext && b == 8'h6B)  push_key(2'b01, stop_cyc + SYNC + 1);
      else if (m_ext && b == 8'h74)  push_key(2'b10, stop_cyc + SYNC + 1);
      else if (!m_ext && b == 8'h5A) push_key(2'b11, stop_cyc + SYNC + 1);
      m_ext = 0;
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic ps2_bit(input logic v);
    ps2_data = v;
    repeat (HP) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HP) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par);
    logic [9:0] f;
    f = {(~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 10; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    repeat (HP) @(negedge clk);
    ps2_clk = 1'b0;
    model_frame(b, bad_par, cyc);
    repeat (HP) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_outstanding: %0d expected pulses missing, required 0", name, sb.size());
      sb.delete();
    end
    n_cmp++;
    if (keyboard_signal !== m_last) begin
      n_fail++;
      $display("FAIL %s_hold: keyboard_signal=%0d, required %0d", name, keyboard_signal, m_last);
    end
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if (keyboard_signal !== 2'b00 || key_valid !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: key=%0d valid=%0b err=%0b, required 0 0 0",
               name, keyboard_signal, key_valid, frame_err);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pool [6];
    logic [7:0] b;
    logic [7:0] c5a;
    pool = '{8'hE0, 8'hF0, 8'h75, 8'h6B, 8'h74, 8'h5A};

    // reset state
    repeat (5) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check_zero("after_reset");

    // E0 75 -> up
    send_byte(8'hE0, 0); send_byte(8'h75, 0);
    drain("e0_75");

    // 5A, F0 5A -> enter once, release silent
    send_byte(8'h5A, 0); send_byte(8'hF0, 0); send_byte(8'h5A, 0);
    drain("enter_break");

    // E0 6B, E0 F0 6B, E0 74 -> left, right
    send_byte(8'hE0, 0); send_byte(8'h6B, 0);
    send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h6B, 0);
    send_byte(8'hE0, 0); send_byte(8'h74, 0);
    drain("left_right");

    // typematic repeat of enter
    send_byte(8'h5A, 0); send_byte(8'h5A, 0);
    drain("repeat");

    // parity error, then E0 75
    send_byte(8'h5A, 1);
    send_byte(8'hE0, 0); send_byte(8'h75, 0);
    drain("parity_err");

    // E0 then parity error: prefix must be dropped, so 5A stays enter
    send_byte(8'hE0, 0); send_byte(8'h33, 1); send_byte(8'h5A, 0);
    drain("err_clears_ext");

    // timeout: start + 4 data bits then silence
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
    sb.push_back('{err: 1'b1, key: 2'b00, cyc: -1});
    m_ext = 0; m_brk = 0;
    ps2_data = 1'b1;
    repeat (TMO_US + 100) @(negedge clk);
    drain("timeout");
    send_byte(8'h5A, 0);
    drain("after_timeout");

    // reset mid-frame after bit 5 of 0x5A
    c5a = 8'h5A;
    ps2_bit(1'b0);
    for (int i = 0; i < 6; i++) ps2_bit(c5a[i]);
    rst = 1'b0;
    m_ext = 0; m_brk = 0; m_last = 2'b00;
    repeat (3) @(negedge clk);
    check_zero("mid_frame_reset");
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check_zero("post_reset_idle");
    send_byte(8'h5A, 0);
    drain("after_reset_frame");

    // randomized traffic
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 9) < 7) b = pool[$urandom_range(0, 5)];
      else                          b = 8'($urandom);
      send_byte(b, ($urandom_range(0, 7) == 0));
      drain("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Receives PS/2 keyboard frames and converts the four game keys into the 2-bit `keyboard_signal` code consumed by the Tetris game controller.
- Code mapping: 00 up, 01 left, 10 right, 11 enter.
- `key_valid` is a one-cycle strobe that qualifies each key press.
- The block sits between the board PS/2 pins and the game controller. It filters break codes and unused keys so that only make events of the four keys reach the game logic.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- TIMEOUT_US, 2000, maximum gap between PS/2 clock falling edges inside one frame before the frame is abandoned.
- SYNC_STAGES, 3, synchroniser depth for ps2_clk and ps2_data (minimum 3).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- ps2_clk  input  1  raw PS/2 clock from the keyboard (asynchronous).
- ps2_data  input  1  raw PS/2 data from the keyboard (asynchronous).
- keyboard_signal  output  2  last decoded key: 00 up, 01 left, 10 right, 11 enter.
- key_valid  output  1  one-cycle pulse; keyboard_signal is updated in the same cycle.
- frame_err  output  1  one-cycle pulse on a parity, start, stop or timeout error.

Behaviour:

Reset (rst=0, asynchronous):
- keyboard_signal=00, key_valid=0, frame_err=0.
- Frame FSM goes to IDLE; bit counter=0; ext and brk flags cleared; timeout counter=0.
- Reset during a frame discards the partial frame with no pulses.

Synchronisation:
- ps2_clk and ps2_data each pass through SYNC_STAGES flops.
- A falling edge is detected when the last two stages of the ps2_clk synchroniser read 1 then 0.
- ps2_data is sampled on that same cycle.

Frame FSM (11-bit frame: start 0, 8 data bits LSB first, odd parity, stop 1):
- IDLE: on an edge with data=0, go to DATA and set bit counter=0. An edge with data=1 is ignored and the FSM stays in IDLE.
- DATA: shift in 8 bits, LSB first, then go to PARITY.
- PARITY: capture the parity bit, then go to STOP.
- STOP: on an edge, if data=1 and (XOR of the 8 data bits and the parity bit)=1, emit byte_rdy for one cycle. Otherwise pulse frame_err. Return to IDLE in both cases.
- Timeout: in any state other than IDLE, a counter counts cycles since the last edge. On reaching CLK_HZ/1000000*TIMEOUT_US, go to IDLE, pulse frame_err, and clear ext and brk.
- Any frame_err also clears ext and brk.

Byte decoder (acts on byte_rdy):
- 0xE0: set ext; no output.
- 0xF0: set brk; no output.
- Any other byte with brk=1: clear ext and brk; no output (this is the release of a key).
- Any other byte with brk=0:
  - ext & 0x75 gives 00.
  - ext & 0x6B gives 01.
  - ext & 0x74 gives 10.
  - !ext & 0x5A gives 11.
  - Any other code produces no output.
  - Clear ext in all cases.
- Typematic repeats (repeated make codes) each produce a new key_valid pulse.

Output timing:
- keyboard_signal and key_valid are registered.
- key_valid asserts exactly 2 clk cycles after the cycle in which the stop-bit falling edge is detected.
- keyboard_signal holds its value between pulses.
- key_valid and frame_err are never high in the same cycle.

Decomposition:
- Package ps2_pkg:
  - Scan-code constants SC_EXT=8'hE0, SC_BRK=8'hF0, SC_UP=8'h75, SC_LEFT=8'h6B, SC_RIGHT=8'h74, SC_ENTER=8'h5A.
  - 2-bit key enum KEY_UP/KEY_LEFT/KEY_RIGHT/KEY_ENTER.
  - Frame FSM state enum.
- Sub-module ps2_frame_rx: synchroniser, edge detect, frame FSM and timeout. Outputs byte[7:0], byte_rdy and frame_err.
- The top level holds the ext/brk prefix logic and the key mapping.

Test Plan:
- Send frames E0, 75 at 12.5 kHz PS/2 clock -> exactly one key_valid pulse, keyboard_signal=00, 2 cycles after the last stop edge.
- Send 5A, then F0 5A -> one pulse with keyboard_signal=11; the break sequence produces no pulse.
- Send E0 6B, E0 F0 6B, E0 74 -> two pulses in order: 01 then 10.
- Send 5A with the parity bit flipped -> frame_err pulse, no key_valid. A following valid E0 75 decodes to 00 (flags were cleared).
- Send start bit plus 4 data bits, then hold ps2_clk high for TIMEOUT_US+100 us -> one frame_err pulse and FSM back in IDLE. A following 5A yields 11.
- Assert rst mid-frame (after bit 5 of 0x5A) -> all outputs 0 and no pulses. A subsequent full 5A frame yields keyboard_signal=11 with key_valid.
